// File: rtl/dmem_pkg.sv
// Shared encodings and the byte-enable helper for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  // Reserved size 2'b11 falls through to a full word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage: synchronous byte-enabled write, registered read on one shared address.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: init clear, sized loads/stores, extension.
// DMEM_MISALIGN_TRAP_EN rejects misaligned accesses instead of force-aligning them.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              ready,
  output logic              misaligned
);

  // state    | meaning
  // ST_INIT  | zeroing one word per cycle, requests ignored
  // ST_READY | serving loads and stores

  localparam int IW = $clog2(DEPTH);

  state_t        state, state_n;
  logic [IW-1:0] clr_cnt, clr_cnt_n;

  logic [1:0]    lo_raw, lo_eff;
  logic [IW-1:0] idx;
  logic          blocked;
  logic [31:0]   wdata_rep;
  logic          addr_unused;

  logic          ram_we, ram_re;
  logic [3:0]    ram_be;
  logic [IW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic          ld_req;
  logic          ld_q, uns_q;
  logic [1:0]    size_q, lo_q;
  logic [31:0]   ext_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign lo_raw      = address[1:0];
  assign idx         = address[IW+1:2];
  assign addr_unused = &{1'b0, address[ADDR_W-1:IW+2]};
  assign ready       = (state == ST_READY);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_req, mis_q;

  assign lo_eff  = lo_raw;
  assign blocked = ((size == SZ_HALF) && lo_raw[0]) ||
                   ((size != SZ_BYTE) && (size != SZ_HALF) && (lo_raw != 2'b00));
  assign mis_req = ready && blocked && (MemRead || MemWrite);

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      mis_q      <= mis_req;
      misaligned <= mis_q;
    end
  end
`else
  // Without the trap, the offending low address bits are simply dropped.
  assign lo_eff     = (size == SZ_BYTE) ? lo_raw :
                      (size == SZ_HALF) ? {lo_raw[1], 1'b0} : 2'b00;
  assign blocked    = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign wdata_rep = (size == SZ_BYTE) ? {4{write_data[7:0]}} :
                     (size == SZ_HALF) ? {2{write_data[15:0]}} : write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = idx;
    ram_wdata = wdata_rep;
    ld_req    = 1'b0;
    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_be    = 4'b1111;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        clr_cnt_n = clr_cnt + 1'b1;
        if (clr_cnt == IW'(DEPTH - 1)) state_n = ST_READY;
      end
      ST_READY: begin
        // A store wins over a simultaneous load; the load is dropped.
        if (MemWrite && !blocked) begin
          ram_we = 1'b1;
          ram_be = lane_mask(size, lo_eff);
        end else if (MemRead && !blocked) begin
          ram_re = 1'b1;
          ld_req = 1'b1;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  dmem_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign byte_sel = ram_rdata[8*lo_q +: 8];
  assign half_sel = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    ext_data = ram_rdata;
    case (size_q)
      SZ_BYTE: ext_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_data = ram_rdata;
    endcase
  end

  // Stage 1 tracks the RAM read; stage 2 extends and holds the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      lo_q       <= 2'b00;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      ld_q       <= ld_req;
      uns_q      <= unsigned_ld;
      size_q     <= size;
      lo_q       <= lo_eff;
      read_valid <= ld_q;
      if (ld_q) read_data <= ext_data;
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised successor to the pipeline's single-size data memory, sitting in the MEM stage. It supports byte, halfword and word loads and stores with byte-lane enables, and sign or zero extension on loads. Read data is registered with a fixed one-cycle latency. After reset, an init state machine clears the whole array before the block accepts requests.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DEPTH, 256, number of 32-bit words; power of two, at least 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  load request
- MemWrite  in  1  store request
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend
- address  in  ADDR_W  byte address
- write_data  in  32  store data, right-aligned
- read_data  out  32  extended load result
- read_valid  out  1  one-cycle pulse marking a load result
- ready  out  1  block accepts requests
- misaligned  out  1  one-cycle pulse on a rejected misaligned access

## Operation
- Byte order is little-endian. Lane = address[1:0].
- Word index = address[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- FSM has two states, INIT and READY.
  - rst → INIT with clear counter = 0.
  - In INIT: one word is zeroed per cycle; ready = 0; requests are ignored.
  - When counter reaches DEPTH-1 and that word is written → READY.
  - rst asserted in any state, including mid-init → restart INIT at counter 0.
- Stores (ready=1, MemWrite=1):
  - byte writes write_data[7:0] into lane address[1:0];
  - half writes write_data[15:0] into lanes {address[1],0} and {address[1],1};
  - word writes all four lanes;
  - other lanes are untouched.
- Loads (ready=1, MemRead=1):
  - select the lane or lanes as for stores;
  - extend to 32 bits according to unsigned_ld;
  - a word load ignores unsigned_ld.
- MemRead and MemWrite both high: the store executes, the load is dropped, and read_valid stays 0.
- Misaligned = half with address[0]=1, or word with address[1:0]≠0.

## Timing
- Reset values: read_data 0, read_valid 0, ready 0, misaligned 0.
- ready rises exactly DEPTH cycles after the first clock edge with rst low.
- Load latency: a request sampled at edge N gives read_data and read_valid valid after edge N+1.
  - read_valid lasts one cycle.
  - read_data holds until the next valid load.
- Back-to-back loads are allowed on every cycle (full throughput).
- A store is visible to a load sampled on the following edge. There is no same-cycle forwarding, because simultaneous load and store never coexist.
- misaligned has the same timing as read_valid and applies to both loads and stores.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - misaligned accesses are suppressed: no array write, no read_valid;
  - misaligned pulses one cycle later.
- Not defined:
  - address[1:0] (word) or address[0] (half) is forced to 0 and the access proceeds;
  - misaligned is tied to 0.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum {ST_INIT, ST_READY};
  - function lane_mask(size, addr_lo) returning the 4-bit byte enable.
- Sub-module dmem_ram is the DEPTH×32 storage: synchronous write with 4-bit byte enable, registered read. The top level owns the FSM, alignment check and extension.

## Test plan
- Reset: rst high 2 cycles, then low → ready 0 for 256 cycles, then 1; LW @0x3FC → 0x00000000. Pulse rst at init cycle 100 → ready delayed a further 256 cycles from release.
- SW 0xA5A5A5A5 @0x10, then LW @0x10 → read_data 0xA5A5A5A5 with read_valid one cycle after the load. LW @0x30 (never written) → 0x00000000.
- SW 0x12345678 @0x20; SB 0x80 @0x21:
  - LW @0x20 → 0x12348078;
  - LB @0x21 → 0xFFFFFF80;
  - LBU @0x21 → 0x00000080.
- SH 0xBEEF @0x22:
  - LH @0x22 → 0xFFFFBEEF;
  - LHU → 0x0000BEEF;
  - LW @0x20 → 0xBEEF8078.
- With DMEM_MISALIGN_TRAP_EN: SW 0xDEADBEEF @0x13 → misaligned pulse, word @0x10 still 0xA5A5A5A5; LH @0x11 → misaligned, no read_valid. Without the macro: LW @0x13 → contents of 0x10.
- Wrap and contention:
  - SW 0xCAFEF00D @0x400 → LW @0x000 returns 0xCAFEF00D;
  - MemRead=MemWrite=1 → store done, read_valid stays 0.
